// File: rtl/viterbi_rx_k3_if.sv
// Symbol-in / decision-out bundle for the K=3 Viterbi receiver.
// master = upstream driver and bit sink, slave = decoder.
interface viterbi_rx_k3_if;
  logic       restart;
  logic       in_valid;
  logic [1:0] parities;
  logic [1:0] erase;
  logic       out;
  logic       out_valid;

  modport master (
    output restart, in_valid, parities, erase,
    input  out, out_valid
  );

  modport slave (
    input  restart, in_valid, parities, erase,
    output out, out_valid
  );
endinterface

// File: rtl/viterbi_rx_k3.sv
// Hard-decision Viterbi decoder for the rate-1/2 K=3 (7,5) code.
// Four-state ACS with register-exchange survivors and erasure-aware branch metrics.
module viterbi_rx_k3 #(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned METRIC_W = 6
) (
  input logic           CLK,
  input logic           RST,
  viterbi_rx_k3_if.slave bus
);

  localparam int unsigned NUM_ST = 4;
  localparam int unsigned FILL_W = $clog2(TB_DEPTH + 1);
  localparam int unsigned COST_W = METRIC_W + 1;
  localparam logic [METRIC_W-1:0] INIT_OTHER = METRIC_W'(4);

  typedef logic [METRIC_W-1:0] metric_t;
  typedef logic [TB_DEPTH-1:0] path_t;

  metric_t           metric_q [NUM_ST];
  metric_t           metric_d [NUM_ST];
  path_t             path_q   [NUM_ST];
  path_t             path_d   [NUM_ST];
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              acc_q, acc_d;
  logic              out_q, out_d;
  logic              out_valid_q, out_valid_d;

  logic [COST_W-1:0] cost_lo [NUM_ST];
  logic [COST_W-1:0] cost_hi [NUM_ST];
  logic              take_hi [NUM_ST];
  metric_t           acs_m   [NUM_ST];
  path_t             acs_p   [NUM_ST];
  logic              all_msb;
  logic [1:0]        best_st;

  // Hamming distance to the encoder output of (old_s, u), skipping erased bits.
  function automatic logic [1:0] branch_metric(input logic [1:0] old_s,
                                               input logic       u,
                                               input logic [1:0] rx,
                                               input logic [1:0] er);
    logic [1:0] exp_p;
    logic       e1, e0;
    exp_p[1] = u ^ old_s[0] ^ old_s[1];
    exp_p[0] = u ^ old_s[1];
    e1 = (rx[1] ^ exp_p[1]) & ~er[1];
    e0 = (rx[0] ^ exp_p[0]) & ~er[0];
    return {1'b0, e1} + {1'b0, e0};
  endfunction

  // New state {b,u} chooses between old {0,b} and {1,b}; ties keep {0,b}.
  always_comb begin
    all_msb = 1'b1;
    for (int ns = 0; ns < NUM_ST; ns++) begin
      cost_lo[ns] = COST_W'(metric_q[{1'b0, 1'(ns >> 1)}])
                  + COST_W'(branch_metric({1'b0, 1'(ns >> 1)}, 1'(ns), bus.parities, bus.erase));
      cost_hi[ns] = COST_W'(metric_q[{1'b1, 1'(ns >> 1)}])
                  + COST_W'(branch_metric({1'b1, 1'(ns >> 1)}, 1'(ns), bus.parities, bus.erase));
      take_hi[ns] = cost_hi[ns] < cost_lo[ns];
      acs_m[ns]   = take_hi[ns] ? METRIC_W'(cost_hi[ns]) : METRIC_W'(cost_lo[ns]);
      acs_p[ns]   = take_hi[ns] ? {path_q[{1'b1, 1'(ns >> 1)}][TB_DEPTH-2:0], 1'(ns)}
                                : {path_q[{1'b0, 1'(ns >> 1)}][TB_DEPTH-2:0], 1'(ns)};
      all_msb     = all_msb & acs_m[ns][METRIC_W-1];
    end
    // Clearing a common MSB subtracts the same amount from every state.
    if (all_msb) begin
      for (int ns = 0; ns < NUM_ST; ns++) begin
        acs_m[ns][METRIC_W-1] = 1'b0;
      end
    end
  end

  always_comb begin
    best_st = 2'd0;
    for (int i = 1; i < NUM_ST; i++) begin
      if (metric_q[i] < metric_q[best_st]) begin
        best_st = 2'(i);
      end
    end
  end

  always_comb begin
    metric_d    = metric_q;
    path_d      = path_q;
    fill_d      = fill_q;
    acc_d       = 1'b0;
    out_d       = out_q;
    out_valid_d = 1'b0;

    // Decision for the symbol accepted on the previous edge, even across restart.
    if (acc_q && (fill_q == FILL_W'(TB_DEPTH))) begin
      out_valid_d = 1'b1;
      out_d       = path_q[best_st][TB_DEPTH-1];
    end

    if (bus.restart) begin
      for (int i = 0; i < NUM_ST; i++) begin
        metric_d[i] = (i == 0) ? '0 : INIT_OTHER;
        path_d[i]   = '0;
      end
      fill_d = '0;
    end else if (bus.in_valid) begin
      metric_d = acs_m;
      path_d   = acs_p;
      acc_d    = 1'b1;
      if (fill_q != FILL_W'(TB_DEPTH)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_ST; i++) begin
        metric_q[i] <= (i == 0) ? '0 : INIT_OTHER;
        path_q[i]   <= '0;
      end
      fill_q      <= '0;
      acc_q       <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      metric_q    <= metric_d;
      path_q      <= path_d;
      fill_q      <= fill_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule
